// File: rtl/idex_skid_reg.sv
// ============================================================================
// idex_skid_reg : ID/EX stage register with valid/ready, optional skid entry,
//                 synchronous flush and saturating stall counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module idex_skid_reg #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_reg1_data,
  input  logic [DATA_W-1:0]   in_reg2_data,
  input  logic [RADDR_W-1:0]  in_wr_address,
  input  logic                in_wr_enable,
  input  logic [ALUOP_W-1:0]  in_alu_op,
  input  logic [ALUSEL_W-1:0] in_alu_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_reg1_data,
  output logic [DATA_W-1:0]   out_reg2_data,
  output logic [RADDR_W-1:0]  out_wr_address,
  output logic                out_wr_enable,
  output logic [ALUOP_W-1:0]  out_alu_op,
  output logic [ALUSEL_W-1:0] out_alu_sel,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PAYLOAD_W = 2*DATA_W + RADDR_W + 1 + ALUOP_W + ALUSEL_W;
  localparam int WE_BIT    = ALUOP_W + ALUSEL_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic                 w_accept;
  logic                 w_emit;
  logic [PAYLOAD_W-1:0] w_in_bundle;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_in_bundle = {in_reg1_data, in_reg2_data, in_wr_address,
                        in_wr_enable, in_alu_op, in_alu_sel};
  assign w_accept    = in_valid & in_ready;
  assign w_emit      = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_emit && !w_accept)      w_next_state = ST_EMPTY;
          else if (!w_emit && w_accept) w_next_state = (SKID != 0) ? ST_FULL : ST_ONE;
        end
        ST_FULL:  if (w_emit) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Output logic
  always_comb begin
    out_valid = (r_state != ST_EMPTY);
  end

  generate
    if (SKID != 0) begin : g_ready_registered
      // Decoded from state flops only, so no combinational path from out_ready
      assign in_ready = (r_state != ST_FULL);
    end else begin : g_ready_passthru
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  // Main payload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
    end else if (flush) begin
      r_main <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_main <= w_in_bundle;
        ST_ONE: begin
          if (w_emit) begin
            if (w_accept) r_main <= w_in_bundle;
            else          r_main[WE_BIT] <= 1'b0;
          end
        end
        ST_FULL:  if (w_emit) r_main <= r_skid;
        default:  r_main <= '0;
      endcase
    end
  end

  // Skid entry only fills when the output is stalled and decode pushes anyway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (flush) begin
      r_skid <= '0;
    end else if ((SKID != 0) && (r_state == ST_ONE) && !w_emit && w_accept) begin
      r_skid <= w_in_bundle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && !flush && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign {out_reg1_data, out_reg2_data, out_wr_address,
          out_wr_enable, out_alu_op, out_alu_sel} = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_idex_skid_reg.sv
// Testbench for idex_skid_reg: scoreboard on the SKID=1 instance plus
// directed scenarios on both the SKID=1 and SKID=0 builds.
`default_nettype none

module tb_idex_skid_reg;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wa;
    logic        we;
    logic [7:0]  op;
    logic [2:0]  sel;
  } bundle_t;

  logic        clk, rst_n, flush, cnt_clr;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_reg1_data, in_reg2_data, out_reg1_data, out_reg2_data;
  logic [4:0]  in_wr_address, out_wr_address;
  logic        in_wr_enable, out_wr_enable;
  logic [7:0]  in_alu_op, out_alu_op;
  logic [2:0]  in_alu_sel, out_alu_sel;
  logic [15:0] stall_cnt;

  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] out_reg1_data0, out_reg2_data0;
  logic [4:0]  out_wr_address0;
  logic        out_wr_enable0;
  logic [7:0]  out_alu_op0;
  logic [2:0]  out_alu_sel0;
  logic [15:0] stall_cnt0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  idex_skid_reg #(.SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg1_data(in_reg1_data), .in_reg2_data(in_reg2_data),
    .in_wr_address(in_wr_address), .in_wr_enable(in_wr_enable),
    .in_alu_op(in_alu_op), .in_alu_sel(in_alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg1_data(out_reg1_data), .out_reg2_data(out_reg2_data),
    .out_wr_address(out_wr_address), .out_wr_enable(out_wr_enable),
    .out_alu_op(out_alu_op), .out_alu_sel(out_alu_sel),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  idex_skid_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_reg1_data(in_reg1_data), .in_reg2_data(in_reg2_data),
    .in_wr_address(in_wr_address), .in_wr_enable(in_wr_enable),
    .in_alu_op(in_alu_op), .in_alu_sel(in_alu_sel),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_reg1_data(out_reg1_data0), .out_reg2_data(out_reg2_data0),
    .out_wr_address(out_wr_address0), .out_wr_enable(out_wr_enable0),
    .out_alu_op(out_alu_op0), .out_alu_sel(out_alu_sel0),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: occupancy of the queue is the model of the stage state
  bundle_t     q[$];
  bundle_t     cur, inb;
  logic [15:0] mcnt;
  logic        ev, er;

  always @(negedge rst_n) begin
    q.delete();
    mcnt = '0;
  end

  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      ev  = (q.size() > 0);
      er  = (q.size() < 2);
      cur = {out_reg1_data, out_reg2_data, out_wr_address, out_wr_enable, out_alu_op, out_alu_sel};
      inb = {in_reg1_data, in_reg2_data, in_wr_address, in_wr_enable, in_alu_op, in_alu_sel};
      total_cnt++;
      if (out_valid !== ev || in_ready !== er)
        $display("FAIL sb_handshake t=%0t: valid/ready got %b%b expected %b%b", $time, out_valid, in_ready, ev, er);
      else pass_cnt++;
      total_cnt++;
      if (stall_cnt !== mcnt)
        $display("FAIL sb_stall_cnt t=%0t: got %h expected %h", $time, stall_cnt, mcnt);
      else pass_cnt++;
      total_cnt++;
      if (ev) begin
        if (cur !== q[0]) $display("FAIL sb_payload t=%0t: got %h expected %h", $time, cur, q[0]);
        else pass_cnt++;
      end else begin
        if (out_wr_enable !== 1'b0) $display("FAIL sb_idle_wren t=%0t: got %b expected 0", $time, out_wr_enable);
        else pass_cnt++;
      end
      if (cnt_clr) mcnt = '0;
      else if (in_valid && !er && !flush && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (ev && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && er) q.push_back(inb);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    in_valid      = v;
    in_reg1_data  = d;
    in_reg2_data  = ~d;
    in_wr_address = d[4:0];
    in_wr_enable  = 1'b1;
    in_alu_op     = d[7:0] ^ 8'h5A;
    in_alu_sel    = d[2:0];
    out_ready     = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_hs: valid/ready got %b%b expected 01", out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({out_reg1_data, out_reg2_data, out_wr_address, out_wr_enable, out_alu_op, out_alu_sel, stall_cnt} !== '0)
      $display("FAIL reset_payload: got %h/%h cnt %h expected all 0", out_reg1_data, out_reg2_data, stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_reg1_data0 !== 32'h0)
      $display("FAIL reset_skid0: valid/ready got %b%b data %h expected 01 0", out_valid0, in_ready0, out_reg1_data0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], 1'b1);
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_reg1_data !== d[i-1])
          $display("FAIL stream_out[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_reg1_data, d[i-1]);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b1);
    #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_reg1_data !== 32'h44 || stall_cnt !== 16'h0)
      $display("FAIL stream_last: got v=%b %h cnt %h expected v=1 44 cnt 0", out_valid, out_reg1_data, stall_cnt);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'hA, 1'b0); @(negedge clk);
    drive(1'b1, 32'hB, 1'b0); #1;
    total_cnt++;
    if (out_reg1_data !== 32'hA || in_ready !== 1'b1)
      $display("FAIL bp_second: got %h ready %b expected a ready 1", out_reg1_data, in_ready);
    else pass_cnt++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC, 1'b0); #1;
      total_cnt++;
      if (in_ready !== 1'b0 || out_reg1_data !== 32'hA)
        $display("FAIL bp_blocked[%0d]: ready %b data %h expected 0 a", i, in_ready, out_reg1_data);
      else pass_cnt++;
      @(negedge clk);
    end
    drive(1'b1, 32'hC, 1'b1); #1;
    total_cnt++;
    if (stall_cnt !== 16'd3 || in_ready !== 1'b0 || out_reg1_data !== 32'hA)
      $display("FAIL bp_release: cnt %h ready %b data %h expected 3 0 a", stall_cnt, in_ready, out_reg1_data);
    else pass_cnt++;
    @(negedge clk);
    drive(1'b1, 32'hC, 1'b1); #1;
    total_cnt++;
    if (out_reg1_data !== 32'hB || in_ready !== 1'b1)
      $display("FAIL bp_outB: data %h ready %b expected b 1", out_reg1_data, in_ready);
    else pass_cnt++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1); #1;
    total_cnt++;
    if (out_reg1_data !== 32'hC || out_valid !== 1'b1 || stall_cnt !== 16'd4)
      $display("FAIL bp_outC: data %h v %b cnt %h expected c 1 4", out_reg1_data, out_valid, stall_cnt);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_flush_full();
    drive(1'b1, 32'hA1, 1'b0); @(negedge clk);
    drive(1'b1, 32'hB2, 1'b0); @(negedge clk);
    drive(1'b1, 32'hD4, 1'b0); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wr_enable !== 1'b0)
      $display("FAIL flush_hs: v/r/we got %b%b%b expected 010", out_valid, in_ready, out_wr_enable);
    else pass_cnt++;
    total_cnt++;
    if ({out_reg1_data, out_reg2_data, out_wr_address, out_alu_op, out_alu_sel} !== '0)
      $display("FAIL flush_payload: got %h %h %h %h %h expected 0", out_reg1_data, out_reg2_data,
               out_wr_address, out_alu_op, out_alu_sel);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_reg1_data === 32'hD4)
      $display("FAIL flush_drop: v %b data %h expected v 0 and no d4", out_valid, out_reg1_data);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_skid0();
    drive(1'b0, 32'h55, 1'b1);
    in_valid0 = 1'b1; out_ready0 = 1'b0; #1;
    total_cnt++;
    if (in_ready0 !== 1'b1) $display("FAIL s0_empty_ready: got %b expected 1", in_ready0);
    else pass_cnt++;
    @(negedge clk);
    drive(1'b0, 32'h66, 1'b1); #1;
    total_cnt++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_reg1_data0 !== 32'h55)
      $display("FAIL s0_stall: v %b r %b data %h expected 1 0 55", out_valid0, in_ready0, out_reg1_data0);
    else pass_cnt++;
    #1 out_ready0 = 1'b1; #1;
    total_cnt++;
    if (in_ready0 !== 1'b1) $display("FAIL s0_comb_ready: got %b expected 1", in_ready0);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (out_valid0 !== 1'b1 || out_reg1_data0 !== 32'h66)
      $display("FAIL s0_load: v %b data %h expected 1 66", out_valid0, out_reg1_data0);
    else pass_cnt++;
    in_valid0 = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if (out_valid0 !== 1'b0 || out_wr_enable0 !== 1'b0 || stall_cnt0 !== 16'h0)
      $display("FAIL s0_drain: v %b we %b cnt %h expected 0 0 0", out_valid0, out_wr_enable0, stall_cnt0);
    else pass_cnt++;
    out_ready0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_counter();
    for (int i = 0; i < (1 << 16) + 7; i++) begin
      drive(1'b1, 32'hC0 + i, 1'b0);
      @(negedge clk);
    end
    #1;
    total_cnt++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL cnt_sat: got %h expected ffff", stall_cnt);
    else pass_cnt++;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; #1;
    total_cnt++;
    if (stall_cnt !== 16'h0) $display("FAIL cnt_clr: got %h expected 0", stall_cnt);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (stall_cnt !== 16'h1) $display("FAIL cnt_restart: got %h expected 1", stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'h0 || out_reg1_data !== 32'h0)
      $display("FAIL areset: v %b r %b cnt %h data %h expected 0 1 0 0", out_valid, in_ready, stall_cnt, out_reg1_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h77, 1'b1); #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL areset_idle: v %b expected 0", out_valid);
    else pass_cnt++;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1); #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_reg1_data !== 32'h77)
      $display("FAIL areset_first: v %b data %h expected 1 77", out_valid, out_reg1_data);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_skid0();
    test_counter();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idex_skid_reg.md
Name: idex_skid_reg

Overview:
- Parametrised ID/EX pipeline stage register between decode and execute. Carries operands, write-back address/enable and ALU op/select.
- Adds a valid/ready handshake and an optional 1-entry skid buffer, so execute can back-pressure decode without a combinational ready path.
- Adds a synchronous flush for branch/exception squash, and a saturating back-pressure performance counter.

Parameters:
- DATA_W, 32, operand width (reg1/reg2 data)
- RADDR_W, 5, register-file write address width
- ALUOP_W, 8, ALU op code width
- ALUSEL_W, 3, ALU select width
- SKID, 1, 1 = skid buffer present (registered in_ready); 0 = single register, in_ready = out_ready | ~out_valid
- CNT_W, 16, width of stall performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  decode presents a valid bundle
- in_ready  out  1  stage can accept this cycle
- in_reg1_data  in  DATA_W  operand 1
- in_reg2_data  in  DATA_W  operand 2
- in_wr_address  in  RADDR_W  write-back register address
- in_wr_enable  in  1  write-back enable
- in_alu_op  in  ALUOP_W  ALU op
- in_alu_sel  in  ALUSEL_W  ALU select
- out_valid  out  1  output bundle valid
- out_ready  in  1  execute accepts output this cycle
- out_reg1_data, out_reg2_data  out  DATA_W  registered operands
- out_wr_address  out  RADDR_W  registered write address
- out_wr_enable  out  1  registered write enable, 0 whenever out_valid=0
- out_alu_op  out  ALUOP_W  registered op
- out_alu_sel  out  ALUSEL_W  registered select
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Reset (async, rst_n=0): state EMPTY, out_valid=0, in_ready=1, all payload outputs 0, skid entry invalid and zero, stall_cnt=0.
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready. Latency in→out is 1 cycle. Order is strictly FIFO; no bundle is dropped or duplicated except by flush.
- SKID=1 states: EMPTY (main invalid), ONE (main valid, skid empty), FULL (main and skid valid). in_ready = (state != FULL), decoded from state flops only.
  - EMPTY: accept → main<=in, go ONE.
  - ONE, emit & accept: main<=in, stay ONE.
  - ONE, emit & ~accept: go EMPTY.
  - ONE, ~emit & accept: skid<=in, go FULL.
  - ONE, ~emit & ~accept: hold.
  - FULL, emit: main<=skid, go ONE. No accept is possible in FULL.
  - FULL, ~emit: hold all.
- SKID=0: only EMPTY/ONE. in_ready = out_ready | ~out_valid (combinational). Transitions as in ONE above, except no FULL state.
- Payload outputs stay stable while out_valid=1 and out_ready=0.
- On transition to EMPTY, out_wr_enable is cleared to 0. Other payload fields hold their last value; consumers qualify them with out_valid.
- flush=1 overrides every other event:
  - Next state is EMPTY; main and skid are invalidated.
  - All main payload registers clear to 0, so a bubble equals the reset NOP.
  - A bundle presented on the flush cycle is discarded, even if in_ready=1.
  - An emit on the flush cycle still counts as taken by execute.
- stall_cnt: increments by 1 when in_valid & ~in_ready and flush=0; saturates at all-ones. cnt_clr has priority over increment and is not affected by flush.
- Reset asserted mid-operation returns everything to reset values immediately; no bundle survives.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 4 cycles with reg1_data 0x11,0x22,0x33,0x44 → out_valid=1 from cycle 1, outputs 0x11..0x44 on consecutive cycles, in_ready constantly 1, stall_cnt=0.
- Back-pressure (SKID=1):
  - Send A=0xA, B=0xB, C=0xC with out_ready=0 → A held at output, B in skid, in_ready=0 from the cycle after B; C held upstream, stall_cnt increments once per blocked cycle.
  - Then out_ready=1 → output A, B, C in order with no loss.
- Flush in FULL: flush=1 with A/B held and new D presented → next cycle out_valid=0, in_ready=1, out_wr_enable=0, all payload outputs 0; D never appears at the output.
- SKID=0 build: out_valid=1, out_ready=0 → in_ready=0 in the same cycle; raising out_ready=1 → in_ready=1 combinationally, and the new bundle loads on that edge.
- Counter: force 2^CNT_W+5 blocked cycles → stall_cnt stays at 0xFFFF. Assert cnt_clr together with a blocked cycle → stall_cnt=0.
- Async reset mid-FULL: rst_n low between clock edges → outputs immediately 0, out_valid=0, in_ready=1. After release, first accepted bundle appears 1 cycle later.
